// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM/WB destination registers, selects operand forwarding and load-use stalls.
// Define HAZARD_FWD_EN for forwarding; otherwise any pending write to a source register stalls until it retires.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_probe,
  input  logic [4:0]       rt_probe,
  input  logic             id_valid,
  input  logic             id_reg_write,
  input  logic [4:0]       id_dst,
  input  logic             id_mem_read,
  input  logic             ex_jump_taken,
  output logic [1:0]       ctrl_rs,
  output logic [1:0]       ctrl_rt,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [4:0] dst;
    logic       load;
  } entry_t;

  entry_t           r_ex, r_mem, r_wb;
  logic [CNT_W-1:0] r_cnt;
  entry_t           w_id;
  logic             w_rs_ex, w_rs_mem, w_rs_wb;
  logic             w_rt_ex, w_rt_mem, w_rt_wb;

  // r0 is hard-wired zero, so a write to it never creates a dependency
  function automatic logic hit(input entry_t e, input logic [4:0] p);
    return e.valid && e.write && (e.dst == p) && (p != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex, input logic mem, input logic wb);
    if (ex)       return 2'b01;
    else if (mem) return 2'b10;
    else if (wb)  return 2'b11;
    else          return 2'b00;
  endfunction

  always_comb begin
    w_id     = '{valid: id_valid, write: id_reg_write, dst: id_dst, load: id_mem_read};
    w_rs_ex  = hit(r_ex,  rs_probe);
    w_rs_mem = hit(r_mem, rs_probe);
    w_rs_wb  = hit(r_wb,  rs_probe);
    w_rt_ex  = hit(r_ex,  rt_probe);
    w_rt_mem = hit(r_mem, rt_probe);
    w_rt_wb  = hit(r_wb,  rt_probe);
  end

  assign flush = ex_jump_taken;

  always_comb begin
    ctrl_rs = 2'b00;
    ctrl_rt = 2'b00;
    stall   = 1'b0;
`ifdef HAZARD_FWD_EN
    if (id_valid) begin
      ctrl_rs = fwd_sel(w_rs_ex, w_rs_mem, w_rs_wb);
      ctrl_rt = fwd_sel(w_rt_ex, w_rt_mem, w_rt_wb);
      // Only a load still in EX has no data to forward yet
      stall   = r_ex.load && (w_rs_ex || w_rt_ex) && !flush;
    end
`else
    if (id_valid)
      stall = (w_rs_ex || w_rs_mem || w_rs_wb || w_rt_ex || w_rt_mem || w_rt_wb) && !flush;
`endif
  end

  // Shadow pipeline: a stalled or flushed ID instruction enters EX as a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= (stall || flush) ? entry_t'('0) : w_id;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (stall && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign stall_count = r_cnt;

endmodule
